// File: rtl/ctrl_seq.sv
// ctrl_seq: multi-cycle CPU control sequencer.
// It registers the present state, decodes the datapath controls combinationally
// from the state, opcode and zero flag, and tracks retired instructions and
// memory stalls.
module ctrl_seq #(
  parameter int CNT_W    = 16,
  parameter int READY_EN = 1,
  parameter int STEP_EN  = 1,
  parameter int TIMEOUT  = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  input  logic             step_mode,
  input  logic             resume,
  output logic [3:0]       ps,
  output logic             mem_rd,
  output logic             load_ir,
  output logic             halt,
  output logic             inc_pc,
  output logic             load_ac,
  output logic             load_pc,
  output logic             mem_wr,
  output logic             data_e,
  output logic [CNT_W-1:0] instr_count,
  output logic             mem_timeout
);

  typedef enum logic [3:0] {
    INST_ADDR  = 4'd0,
    INST_FETCH = 4'd1,
    INST_LOAD  = 4'd2,
    IDLE       = 4'd3,
    OP_ADDR    = 4'd4,
    OP_FETCH   = 4'd5,
    ALU_OP     = 4'd6,
    STORE      = 4'd7,
    HALTED     = 4'd8
  } state_t;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  // The stall counter only has to reach TIMEOUT, so it is sized to hold that value.
  localparam int SC_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [SC_W-1:0] STALL_LIM = SC_W'(TIMEOUT);

  state_t           state_reg;
  state_t           state_next;
  logic [CNT_W-1:0] count_reg;
  logic [SC_W-1:0]  stall_reg;
  logic [SC_W-1:0]  stall_sat;
  logic             timeout_reg;
  logic             alu_op;
  logic             ready_eff;
  logic             step_eff;
  logic             stall;

  // An ALU-type opcode is one that reads an operand from memory.
  assign alu_op    = (opcode == OP_ADD) || (opcode == OP_AND) ||
                     (opcode == OP_XOR) || (opcode == OP_LDA);
  assign ready_eff = (READY_EN != 0) ? mem_ready : 1'b1;
  assign step_eff  = (STEP_EN != 0) ? step_mode : 1'b0;

  // A stall is a fetch state that is waiting on memory.
  assign stall = !ready_eff &&
                 ((state_reg == INST_FETCH) || ((state_reg == OP_FETCH) && alu_op));

  assign stall_sat = (stall_reg == STALL_LIM) ? stall_reg : stall_reg + 1'b1;

  assign ps          = state_reg;
  assign instr_count = count_reg;
  assign mem_timeout = timeout_reg;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= INST_ADDR;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: a fixed ring with stall holds and halt exits.
  always_comb begin
    state_next = INST_ADDR;
    case (state_reg)
      INST_ADDR:  state_next = INST_FETCH;
      INST_FETCH: state_next = stall ? INST_FETCH : INST_LOAD;
      INST_LOAD:  state_next = IDLE;
      IDLE:       state_next = OP_ADDR;
      OP_ADDR:    state_next = (opcode == OP_HLT) ? HALTED : OP_FETCH;
      OP_FETCH:   state_next = stall ? OP_FETCH : ALU_OP;
      ALU_OP:     state_next = STORE;
      STORE:      state_next = step_eff ? HALTED : INST_ADDR;
      HALTED:     state_next = resume ? INST_ADDR : HALTED;
      default:    state_next = INST_ADDR;
    endcase
  end

  // Output decode from present state, opcode and zero flag.
  always_comb begin
    mem_rd  = 1'b0;
    load_ir = 1'b0;
    halt    = 1'b0;
    inc_pc  = 1'b0;
    load_ac = 1'b0;
    load_pc = 1'b0;
    mem_wr  = 1'b0;
    data_e  = 1'b0;
    case (state_reg)
      INST_FETCH: begin
        mem_rd = 1'b1;
      end
      INST_LOAD, IDLE: begin
        mem_rd  = 1'b1;
        load_ir = 1'b1;
      end
      OP_ADDR: begin
        inc_pc = 1'b1;
        halt   = (opcode == OP_HLT);
      end
      OP_FETCH: begin
        mem_rd = alu_op;
      end
      ALU_OP: begin
        mem_rd  = alu_op;
        load_ac = alu_op;
        inc_pc  = (opcode == OP_SKZ) && zero;
        load_pc = (opcode == OP_JMP);
      end
      STORE: begin
        mem_rd  = alu_op;
        load_ac = alu_op;
        inc_pc  = (opcode == OP_JMP);
        load_pc = (opcode == OP_JMP);
        mem_wr  = (opcode == OP_STO);
        data_e  = (opcode == OP_STO);
      end
      HALTED: begin
        halt = 1'b1;
      end
      default: begin
        mem_rd = 1'b0;
      end
    endcase
  end

  // Retired-instruction counter: every exit from STORE is one retirement.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (state_reg == STORE) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  // Stall watchdog: a saturating count of consecutive stalls and a sticky flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_reg   <= '0;
      timeout_reg <= 1'b0;
    end else begin
      stall_reg <= stall ? stall_sat : '0;
      if ((state_reg == HALTED) && resume) begin
        timeout_reg <= 1'b0;
      end else if ((TIMEOUT != 0) && stall && (stall_sat == STALL_LIM)) begin
        timeout_reg <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ctrl_seq.sv
// tb_ctrl_seq: directed stimulus for ctrl_seq with a scoreboard of expected
// per-cycle outputs, checked with immediate assertions.
module tb_ctrl_seq;

  logic        clk;
  logic        rst;
  logic [2:0]  opcode;
  logic        zero;
  logic        mem_ready;
  logic        step_mode;
  logic        resume;

  logic [3:0]  ps;
  logic        mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr, data_e;
  logic [15:0] instr_count;
  logic        mem_timeout;

  logic [3:0]  ps2;
  logic        mem_rd2, load_ir2, halt2, inc_pc2, load_ac2, load_pc2, mem_wr2, data_e2;
  logic [1:0]  instr_count2;
  logic        mem_timeout2;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0]  ps;
    logic [7:0]  ctrl;
    logic [15:0] cnt;
    logic        to;
    logic [1:0]  cnt2;
  } exp_t;

  exp_t sb[$];

  // Reference model state.
  logic [15:0] m_cnt;
  logic        m_to;
  int          m_sc;

  localparam logic [2:0] HLT = 3'd0, SKZ = 3'd1, ADD = 3'd2, AND_ = 3'd3;
  localparam logic [2:0] XOR_ = 3'd4, LDA = 3'd5, STO = 3'd6, JMP = 3'd7;

  ctrl_seq #(.CNT_W(16), .READY_EN(1), .STEP_EN(1), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .step_mode(step_mode), .resume(resume), .ps(ps), .mem_rd(mem_rd),
    .load_ir(load_ir), .halt(halt), .inc_pc(inc_pc), .load_ac(load_ac),
    .load_pc(load_pc), .mem_wr(mem_wr), .data_e(data_e),
    .instr_count(instr_count), .mem_timeout(mem_timeout)
  );

  ctrl_seq #(.CNT_W(2), .READY_EN(1), .STEP_EN(1), .TIMEOUT(15)) dut2 (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .step_mode(step_mode), .resume(resume), .ps(ps2), .mem_rd(mem_rd2),
    .load_ir(load_ir2), .halt(halt2), .inc_pc(inc_pc2), .load_ac(load_ac2),
    .load_pc(load_pc2), .mem_wr(mem_wr2), .data_e(data_e2),
    .instr_count(instr_count2), .mem_timeout(mem_timeout2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected controls {mem_rd,load_ir,halt,inc_pc,load_ac,load_pc,mem_wr,data_e}.
  function automatic logic [7:0] dec(input logic [3:0] s, input logic [2:0] op, input logic z);
    logic a;
    logic [7:0] r;
    a = (op >= 3'd2) && (op <= 3'd5);
    case (s)
      4'd1:       r = 8'b1000_0000;
      4'd2, 4'd3: r = 8'b1100_0000;
      4'd4:       r = {2'b00, (op == HLT), 1'b1, 4'b0000};
      4'd5:       r = {a, 7'b0};
      4'd6:       r = {a, 2'b00, (op == SKZ) && z, a, (op == JMP), 2'b00};
      4'd7:       r = {a, 2'b00, (op == JMP), a, (op == JMP), (op == STO), (op == STO)};
      4'd8:       r = 8'b0010_0000;
      default:    r = 8'b0000_0000;
    endcase
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // One cycle: drive inputs, queue the expectation for this cycle, compare, clock, update model.
  task automatic run(input logic [2:0] op, input logic z, input logic rdy,
                     input logic stp, input logic res, input logic r,
                     input logic [3:0] eps);
    exp_t e;
    exp_t got;
    logic stalled;
    opcode = op; zero = z; mem_ready = rdy; step_mode = stp; resume = res; rst = r;
    e.ps   = eps;
    e.ctrl = dec(eps, op, z);
    e.cnt  = m_cnt;
    e.to   = m_to;
    e.cnt2 = m_cnt[1:0];
    sb.push_back(e);
    #2;
    got = sb.pop_front();
    chk("ps", 32'(ps), 32'(got.ps));
    chk("ctrl", 32'({mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr, data_e}),
        32'(got.ctrl));
    chk("instr_count", 32'(instr_count), 32'(got.cnt));
    chk("mem_timeout", 32'(mem_timeout), 32'(got.to));
    chk("instr_count_w2", 32'(instr_count2), 32'(got.cnt2));
    $display("cyc t=%0t op=%0d rdy=%0b stp=%0b res=%0b rst=%0b ps=%0d ctrl=%b cnt=%0d to=%0b",
             $time, op, rdy, stp, res, r, ps,
             {mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr, data_e},
             instr_count, mem_timeout);
    @(posedge clk);
    if (r) begin
      m_cnt = 16'd0; m_to = 1'b0; m_sc = 0;
    end else begin
      stalled = !rdy && ((eps == 4'd1) || ((eps == 4'd5) && (op >= 3'd2) && (op <= 3'd5)));
      if (stalled) begin
        if (m_sc < 15) m_sc++;
        if (m_sc == 15) m_to = 1'b1;
      end else begin
        m_sc = 0;
      end
      if ((eps == 4'd8) && res) m_to = 1'b0;
      if (eps == 4'd7) m_cnt = m_cnt + 16'd1;
    end
    #1;
  endtask

  // A full instruction through the eight-state ring; rdy5 is mem_ready in OP_FETCH.
  task automatic instr(input logic [2:0] op, input logic z, input logic rdy5, input logic stp);
    for (int s = 0; s < 8; s++) begin
      run(op, z, (s == 5) ? rdy5 : 1'b1, stp, 1'b0, 1'b0, 4'(s));
    end
  endtask

  initial begin
    rst = 1'b1; opcode = ADD; zero = 1'b0; mem_ready = 1'b1; step_mode = 1'b0; resume = 1'b0;
    m_cnt = 16'd0; m_to = 1'b0; m_sc = 0;
    repeat (2) @(posedge clk);
    #1;

    // Plain instructions, one state per cycle.
    instr(ADD, 1'b0, 1'b1, 1'b0);
    instr(JMP, 1'b0, 1'b0, 1'b0);   // non-ALU opcode must not stall in OP_FETCH
    instr(SKZ, 1'b1, 1'b1, 1'b0);
    instr(XOR_, 1'b0, 1'b1, 1'b0);  // fourth retirement wraps the 2-bit counter
    instr(AND_, 1'b0, 1'b1, 1'b0);

    // LDA with an instruction-fetch stall, then a 20-cycle operand-fetch stall.
    run(LDA, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    repeat (3) run(LDA, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1);
    run(LDA, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1);
    for (int s = 2; s < 5; s++) run(LDA, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'(s));
    repeat (20) run(LDA, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd5);
    run(LDA, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd5);
    run(LDA, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd6);
    run(LDA, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd7);

    // HLT: halt in OP_ADDR, hold in HALTED, resume clears the timeout flag.
    for (int s = 0; s < 5; s++) run(HLT, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'(s));
    repeat (2) run(HLT, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd8);
    run(HLT, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd8);

    // Single-step STO: store strobes, then HALTED until resume.
    instr(STO, 1'b0, 1'b1, 1'b1);
    run(STO, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd8);
    run(STO, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd8);

    // Reset in the middle of a long operand stall, against resume and step_mode.
    for (int s = 0; s < 5; s++) run(LDA, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'(s));
    repeat (16) run(LDA, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd5);
    run(LDA, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd5);

    // Restart from reset; resume outside HALTED has no effect.
    run(ADD, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    run(ADD, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd1);
    run(ADD, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ctrl_seq.md
CTRL_SEQ -- requirements
Module: ctrl_seq

Interface
REQ-001 Parameter CNT_W, default 16, width of the retired-instruction counter.
REQ-002 Parameter READY_EN, default 1; 1 = fetch states honour mem_ready, 0 = mem_ready ignored (treated as 1).
REQ-003 Parameter STEP_EN, default 1; 1 = step_mode honoured, 0 = step_mode ignored (treated as 0).
REQ-004 Parameter TIMEOUT, default 15, stall-cycle limit for the timeout flag; 0 disables the flag.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 opcode  input  3  HLT=0 SKZ=1 ADD=2 AND=3 XOR=4 LDA=5 STO=6 JMP=7.
REQ-008 zero  input  1  accumulator-zero flag.
REQ-009 mem_ready  input  1  memory read data valid this cycle.
REQ-010 step_mode  input  1  halt after every retired instruction.
REQ-011 resume  input  1  leave HALTED.
REQ-012 ps  output  4  present state: INST_ADDR=0 INST_FETCH=1 INST_LOAD=2 IDLE=3 OP_ADDR=4 OP_FETCH=5 ALU_OP=6 STORE=7 HALTED=8.
REQ-013 mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr, data_e  output  1 each  datapath controls.
REQ-014 instr_count  output  CNT_W  retired-instruction count.
REQ-015 mem_timeout  output  1  sticky stall-timeout flag.

Function
REQ-016 ps SHALL be registered; control outputs SHALL be combinational in ps, opcode, zero; ALUOP means opcode in {ADD,AND,XOR,LDA}.
REQ-017 Decode: INST_ADDR all 0; INST_FETCH mem_rd; INST_LOAD and IDLE mem_rd+load_ir; OP_ADDR inc_pc, halt=(opcode==HLT).
REQ-018 Decode: OP_FETCH mem_rd=ALUOP; ALU_OP mem_rd=load_ac=ALUOP, inc_pc=(SKZ&&zero), load_pc=JMP.
REQ-019 Decode: STORE mem_rd=load_ac=ALUOP, inc_pc=load_pc=JMP, mem_wr=data_e=STO; HALTED halt=1, all others 0.
REQ-020 Sequence INST_ADDR->INST_FETCH->INST_LOAD->IDLE->OP_ADDR->OP_FETCH->ALU_OP->STORE->INST_ADDR, one state per cycle unless stalled.
REQ-021 INST_FETCH, and OP_FETCH when ALUOP, SHALL hold while mem_ready=0 (READY_EN=1), outputs held constant; advance on the cycle mem_ready=1.
REQ-022 OP_ADDR with opcode==HLT SHALL go to HALTED instead of OP_FETCH.
REQ-023 STORE with step_mode=1 (STEP_EN=1) SHALL go to HALTED instead of INST_ADDR.
REQ-024 HALTED SHALL hold until resume=1, then go to INST_ADDR next cycle; resume outside HALTED is ignored.
REQ-025 instr_count SHALL increment by 1 on every exit from STORE, wrap modulo 2^CNT_W; HLT is not counted.
REQ-026 A stall counter SHALL count consecutive stalled cycles; when it reaches TIMEOUT, mem_timeout SHALL set and stay set; it does not affect sequencing.
REQ-027 mem_timeout SHALL clear on reset or on resume accepted in HALTED; the stall counter clears whenever no stall occurs, saturating at TIMEOUT.
REQ-028 Never load_pc&&inc_pc except opcode==JMP in STORE; never load_pc in OP_ADDR or OP_FETCH.

Reset
REQ-029 rst=1 at a clock edge SHALL force ps=INST_ADDR, instr_count=0, mem_timeout=0, stall counter=0, all control outputs 0, from any state including mid-stall and HALTED.
REQ-030 rst SHALL take priority over resume, mem_ready and step_mode in the same cycle.

Verification
REQ-031 ADD, mem_ready=1 always -> 8-cycle loop; load_ac=1 in ALU_OP and STORE; instr_count 0->1 on STORE exit.
REQ-032 JMP -> load_pc=1 in ALU_OP; load_pc=inc_pc=1 in STORE; load_pc=0 in OP_ADDR/OP_FETCH.
REQ-033 LDA, mem_ready=0 for 20 cycles in OP_FETCH, TIMEOUT=15 -> ps stays 5, mem_timeout=1 after 15 stalled cycles, advances when mem_ready=1.
REQ-034 HLT -> halt=1 in OP_ADDR, ps=8 next; resume=1 -> ps=0 next cycle, mem_timeout=0.
REQ-035 step_mode=1, STO -> mem_wr=data_e=1 in STORE, then ps=8; CNT_W=2 with 4 retirements -> instr_count wraps to 0.
REQ-036 rst=1 during OP_FETCH stall -> ps=0, instr_count=0, all controls 0 next cycle.
